// File: rtl/register_file.sv
// Multi-entry register file for the 8085 datapath: two combinational byte read
// ports, one synchronous byte write port and a 16-bit register-pair port.
module register_file #(
   parameter int DATASIZE = 8,
   parameter int ADDRSIZE = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_enb,
   input  logic [ADDRSIZE-1:0]     wr_addr,
   input  logic [DATASIZE-1:0]     wr_data,
   input  logic [ADDRSIZE-1:0]     rd_addr_a,
   output logic [DATASIZE-1:0]     rd_data_a,
   input  logic [ADDRSIZE-1:0]     rd_addr_b,
   output logic [DATASIZE-1:0]     rd_data_b,
   input  logic [ADDRSIZE-2:0]     pair_sel,
   input  logic [1:0]              pair_op,
   input  logic [2*DATASIZE-1:0]   pair_in,
   output logic [2*DATASIZE-1:0]   pair_out,
   output logic                    pair_wrap
);

   localparam int REGCOUNT = 2 ** ADDRSIZE;
   localparam int PW       = 2 * DATASIZE;
   localparam logic [PW-1:0] PAIR_ONE = {{(PW-1){1'b0}}, 1'b1};

   logic [DATASIZE-1:0] r_regs [REGCOUNT];
   logic                r_wrap;

   logic [ADDRSIZE-1:0] w_hi_idx;
   logic [ADDRSIZE-1:0] w_lo_idx;
   logic [PW-1:0]       w_pair_cur;
   logic [PW-1:0]       w_pair_next;
   logic                w_pair_active;
   logic                w_wr_in_pair;
   logic                w_wr_allowed;
   logic                w_wrap_next;

   // Even index holds the high half of a pair, odd index the low half.
   assign w_hi_idx      = {pair_sel, 1'b0};
   assign w_lo_idx      = {pair_sel, 1'b1};
   assign w_pair_cur    = {r_regs[w_hi_idx], r_regs[w_lo_idx]};
   assign w_pair_active = (pair_op != 2'b00);
   assign w_wr_in_pair  = (wr_addr[ADDRSIZE-1:1] == pair_sel);
   assign w_wr_allowed  = wr_enb & ~(w_pair_active & w_wr_in_pair);

   // Next pair value for the requested pair operation.
   always_comb begin
      w_pair_next = w_pair_cur;
      case (pair_op)
         2'b01:   w_pair_next = w_pair_cur + PAIR_ONE;
         2'b10:   w_pair_next = w_pair_cur - PAIR_ONE;
         2'b11:   w_pair_next = pair_in;
         default: w_pair_next = w_pair_cur;
      endcase
   end

   // Wrap detection: increment from all-ones or decrement from zero.
   always_comb begin
      w_wrap_next = 1'b0;
      case (pair_op)
         2'b01:   w_wrap_next = &w_pair_cur;
         2'b10:   w_wrap_next = ~|w_pair_cur;
         default: w_wrap_next = 1'b0;
      endcase
   end

   // Register storage; a colliding byte write is masked so the pair op owns both halves.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < REGCOUNT; i++) begin
            r_regs[i] <= {DATASIZE{1'b0}};
         end
      end else begin
         if (w_wr_allowed) begin
            r_regs[wr_addr] <= wr_data;
         end
         if (w_pair_active) begin
            r_regs[w_hi_idx] <= w_pair_next[PW-1:DATASIZE];
            r_regs[w_lo_idx] <= w_pair_next[DATASIZE-1:0];
         end
      end
   end

   // Wrap flag is refreshed on every edge, so it lasts exactly one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wrap <= 1'b0;
      end else begin
         r_wrap <= w_wrap_next;
      end
   end

   assign rd_data_a = r_regs[rd_addr_a];
   assign rd_data_b = r_regs[rd_addr_b];
   assign pair_out  = w_pair_cur;
   assign pair_wrap = r_wrap;

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Parametrised successor to the single enable-gated register: a multi-entry register file for the 8085 datapath.
- Provides two asynchronous byte read ports, one synchronous byte write port and a register-pair port. The pair port supports 16-bit load, increment and decrement, as needed for BC/DE/HL/SP-style operations.
- Sits between the internal data bus and the ALU/address incrementer.

Parameters:
DATASIZE, 8, width of one register in bits; must be a multiple of 4.
ADDRSIZE, 3, register address width; register count REGCOUNT = 2**ADDRSIZE; pair count = REGCOUNT/2.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset (rst=0 clears the state immediately, regardless of clk)
wr_enb  input  1  byte write enable
wr_addr  input  ADDRSIZE  byte write register index
wr_data  input  DATASIZE  byte write data
rd_addr_a  input  ADDRSIZE  read port A index
rd_data_a  output  DATASIZE  read port A data
rd_addr_b  input  ADDRSIZE  read port B index
rd_data_b  output  DATASIZE  read port B data
pair_sel  input  ADDRSIZE-1  selected pair index p
pair_op  input  2  00 none, 01 increment, 10 decrement, 11 load
pair_in  input  2*DATASIZE  pair load data
pair_out  output  2*DATASIZE  current value of selected pair
pair_wrap  output  1  registered wrap flag from last pair inc/dec

Behaviour:
- Storage: REGCOUNT registers of DATASIZE bits.
  - Pair p = {reg[2p], reg[2p+1]}: even index is the high half, odd index is the low half (B=0, C=1 style).
- Reset (rst=0, asynchronous):
  - All registers go to 0; pair_wrap goes to 0.
  - Reads and pair_out therefore show 0 while rst is held and after release.
  - Reset asserted mid-operation aborts any pending write or pair op; no partial update survives.
- Reads:
  - rd_data_a, rd_data_b and pair_out are combinational from current register state; zero latency.
  - No write-through bypass: a write at edge N is visible on the reads after edge N.
  - Both ports may address the same register.
- Byte write: when wr_enb=1, reg[wr_addr] <= wr_data on the rising edge. When wr_enb=0 the register holds (same semantics as the single register's enable).
- Pair ops, all taking effect on the rising edge:
  - 11 (load): pair <= pair_in.
  - 01 (increment): pair <= pair + 1, modulo 2**(2*DATASIZE).
  - 10 (decrement): pair <= pair - 1, modulo 2**(2*DATASIZE).
  - Carry and borrow propagate from the low register into the high register; the full 2*DATASIZE-bit arithmetic applies.
- pair_wrap (registered):
  - Updated on every edge.
  - Set to 1 for the cycle after an increment from all-ones to 0, or a decrement from 0 to all-ones.
  - Otherwise set to 0, including after op 00, after load, and after non-wrapping inc/dec.
- Collision: pair_op != 00 and wr_enb=1 on the same edge, with wr_addr in the selected pair.
  - The pair op wins both halves; the byte write is discarded.
  - If wr_addr is outside the pair, both updates occur.
- No other priority; unused/idle cycles leave all state unchanged.

Test Plan:
- Reset: drive rst=0 mid-sequence after writing reg[3]=0xAA → all reads and pair_out = 0x00/0x0000 immediately, without waiting for a clk edge; pair_wrap=0.
- Byte write and dual read:
  - Write reg[2]=0x5A with wr_enb=1, then reg[2]=0xA5 with wr_enb=0 → rd_data_a(2)=0x5A and rd_data_b(2)=0x5A after the edge; value unchanged after the disabled write.
- Pair load and halves: pair_sel=1, op=11, pair_in=0x1234 → reg[2]=0x12, reg[3]=0x34, pair_out=0x1234.
- Carry, borrow and wrap:
  - Load 0x00FF then inc → 0x0100, pair_wrap=0.
  - Load 0xFFFF then inc → 0x0000, pair_wrap=1 for exactly one cycle.
  - Dec from 0x0000 → 0xFFFF, pair_wrap=1.
- Collision:
  - pair_sel=0, op=01 on 0x00FF, simultaneous wr_enb=1, wr_addr=1, wr_data=0x77 → pair=0x0100; the byte write is dropped.
  - Same cycle with wr_addr=4 instead → pair=0x0100 and reg[4]=0x77.
- Width scaling: rerun the load/inc/wrap cases with DATASIZE=16 → load 0xFFFFFFFF then inc gives 0x00000000 and pair_wrap=1.
